// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration Avalon-MM master:
// register map of the reconfiguration slave, status bit position and FSM states.
package pll_reconfig_pkg;

  typedef enum logic [5:0] {
    MODE   = 6'd0,
    STATUS = 6'd1,
    START  = 6'd2,
    N_CNT  = 6'd3,
    M_CNT  = 6'd4,
    C_CNT  = 6'd5,
    DPS    = 6'd6,
    M_FRAC = 6'd7,
    BW     = 6'd8,
    CP     = 6'd9
  } pll_reg_e;

  localparam int STATUS_DONE_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP,
    ST_POLL_GAP,
    ST_POLL
  } state_e;

  function automatic logic status_done(input logic [31:0] status_word);
    return status_word[STATUS_DONE_BIT];
  endfunction

endpackage

// File: rtl/pll_cfg_wdog.sv
// Saturating transaction watchdog: cleared on command accept, counts busy cycles,
// flags expiry in the cycle that is the TIMEOUT_CYCLES-th busy cycle. 0 disables it.
module pll_cfg_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Expiry is seen in the busy cycle that brings the count to the limit.
      assign expired_o = (cnt_q == LIMIT) || (en_i && (cnt_q == LIMIT - CW'(1)));
    end else begin : g_no_wdog
      logic unused_wdog;
      assign unused_wdog = ^{clk, reset, clr_i, en_i};
      assign expired_o   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pll_reconfig_master.sv
// Avalon-MM master for the PLL reconfiguration slave: one command in, one
// transaction with watchdog, one response out. Optional START status polling
// is enabled by defining PLL_RECONFIG_STATUS_POLL_EN.
module pll_reconfig_master
  import pll_reconfig_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              avm_read,
  output logic              avm_write,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  state_e            state_q;
  logic              avm_read_q, avm_write_q;
  logic [ADDR_W-1:0] avm_address_q;
  logic [DATA_W-1:0] avm_writedata_q;
  logic              rsp_valid_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic accept, wd_en, wd_expired, start_poll;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign wd_en     = (state_q == ST_XFER) || (state_q == ST_POLL_GAP) || (state_q == ST_POLL);

`ifdef PLL_RECONFIG_STATUS_POLL_EN
  assign start_poll = avm_write_q && (avm_address_q == ADDR_W'(START));
`else
  assign start_poll = 1'b0;
`endif

  pll_cfg_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (accept),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      rsp_rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            avm_read_q      <= !cmd_write;
            avm_write_q     <= cmd_write;
            avm_address_q   <= cmd_addr;
            avm_writedata_q <= cmd_wdata;
            state_q         <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!avm_waitrequest) begin
            // Completion takes priority over a coincident watchdog expiry.
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            if (start_poll) begin
              state_q <= ST_POLL_GAP;
            end else begin
              state_q       <= ST_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_rdata_q   <= avm_read_q ? avm_readdata : '0;
            end
          end else if (wd_expired) begin
            avm_read_q    <= 1'b0;
            avm_write_q   <= 1'b0;
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end
        end
`ifdef PLL_RECONFIG_STATUS_POLL_EN
        ST_POLL_GAP: begin
          if (wd_expired) begin
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end else begin
            state_q       <= ST_POLL;
            avm_read_q    <= 1'b1;
            avm_address_q <= ADDR_W'(STATUS);
          end
        end
        ST_POLL: begin
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            if (status_done(32'(avm_readdata))) begin
              state_q       <= ST_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_rdata_q   <= avm_readdata;
            end else begin
              state_q <= ST_POLL_GAP;
            end
          end else if (wd_expired) begin
            avm_read_q    <= 1'b0;
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state_q       <= ST_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          avm_read_q  <= 1'b0;
          avm_write_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_timeout   = rsp_timeout_q;

endmodule
